// File: rtl/cu_fsm_if.sv
// Control-unit bus: instruction fields and interrupt inputs toward the FSM,
// datapath and memory enables back from it.
interface cu_fsm_if;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;

    logic                intr;
    logic                mie;
    logic [OPCODE_W-1:0] ir6_0;
    logic [FUNCT3_W-1:0] ir14_12;

    logic                PCWrite;
    logic                regWrite;
    logic                memWE2;
    logic                memRDEN1;
    logic                memRDEN2;
    logic                reset;
    logic                csr_WE;
    logic                int_taken;
    logic                mret_exec;

    // Datapath side: presents the instruction and interrupt state, consumes enables.
    modport master (
        output intr, mie, ir6_0, ir14_12,
        input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               reset, csr_WE, int_taken, mret_exec
    );

    // Control-unit side.
    modport slave (
        input  intr, mie, ir6_0, ir14_12,
        output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               reset, csr_WE, int_taken, mret_exec
    );
endinterface

// File: rtl/cu_fsm.sv
// Multi-cycle RISC-V control unit: FETCH/EXEC sequencing, load write-back,
// and interrupt entry with a sticky pending flag.
module cu_fsm (
    input  logic     CLK,
    input  logic     RST,
    cu_fsm_if.slave  bus
);
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SYS    = 7'b1110011;

    localparam logic [FUNCT3_W-1:0] F3_MRET   = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_CSRRW  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_CSRRS  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_CSRRC  = 3'b011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_int_pend;
    logic   w_int_pend_next;
    logic   w_int_req;

    logic   w_pc_write;
    logic   w_reg_write;
    logic   w_mem_we2;
    logic   w_mem_rden1;
    logic   w_mem_rden2;
    logic   w_reset;
    logic   w_csr_we;
    logic   w_int_taken;
    logic   w_mret_exec;

    // A request is held until INTR is entered; a fresh pulse during INTR re-arms it.
    assign w_int_pend_next = bus.intr | (r_int_pend & (r_state != ST_INTR));
    assign w_int_req       = (r_int_pend | bus.intr) & bus.mie;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_INIT;
            r_int_pend <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_int_pend <= w_int_pend_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_we2    = 1'b0;
        w_mem_rden1  = 1'b0;
        w_mem_rden2  = 1'b0;
        w_reset      = 1'b0;
        w_csr_we     = 1'b0;
        w_int_taken  = 1'b0;
        w_mret_exec  = 1'b0;

        unique case (r_state)
            ST_INIT: begin
                w_reset      = 1'b1;
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                w_mem_rden1  = 1'b1;
                w_next_state = ST_EXEC;
            end

            ST_EXEC: begin
                w_pc_write   = 1'b1;
                w_next_state = w_int_req ? ST_INTR : ST_FETCH;
                case (bus.ir6_0)
                    OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        w_reg_write = 1'b1;
                    end
                    OP_STORE: begin
                        w_mem_we2 = 1'b1;
                    end
                    // Loads must finish write-back before an interrupt can be taken.
                    OP_LOAD: begin
                        w_pc_write   = 1'b0;
                        w_mem_rden2  = 1'b1;
                        w_next_state = ST_WB;
                    end
                    OP_SYS: begin
                        case (bus.ir14_12)
                            F3_MRET: w_mret_exec = 1'b1;
                            F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                                w_csr_we    = 1'b1;
                                w_reg_write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end

            ST_WB: begin
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_next_state = w_int_req ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                w_int_taken  = 1'b1;
                w_pc_write   = 1'b1;
                w_next_state = ST_FETCH;
            end

            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    assign bus.PCWrite   = w_pc_write;
    assign bus.regWrite  = w_reg_write;
    assign bus.memWE2    = w_mem_we2;
    assign bus.memRDEN1  = w_mem_rden1;
    assign bus.memRDEN2  = w_mem_rden2;
    assign bus.reset     = w_reset;
    assign bus.csr_WE    = w_csr_we;
    assign bus.int_taken = w_int_taken;
    assign bus.mret_exec = w_mret_exec;
endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: directed instruction/interrupt scenarios
// followed by randomized traffic against an instruction-level reference model.
module tb_cu_fsm;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    cu_fsm_if bus ();

    cu_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output vector order: PCWrite regWrite memWE2 memRDEN1 memRDEN2 reset csr_WE int_taken mret_exec
    localparam int B_PC = 8, B_RW = 7, B_WE2 = 6, B_RD1 = 5, B_RD2 = 4;
    localparam int B_RST = 3, B_CSR = 2, B_INT = 1, B_MRET = 0;

    // Reference model: which step of the instruction cycle the machine is in.
    localparam int M_RESET = 0, M_FETCH = 1, M_EXEC = 2, M_LOADWB = 3, M_TRAP = 4;
    int   m_step;
    bit   m_pending;

    logic [6:0] alu_ops [6] = '{7'b0110011, 7'b0010011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b1100111};
    logic [6:0] all_ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                 7'b1101111, 7'b1100111, 7'b0100011, 7'b1100011,
                                 7'b0000011, 7'b1110011};

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%b exp=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_alu(input logic [6:0] op);
        bit r = 1'b0;
        foreach (alu_ops[k]) if (alu_ops[k] == op) r = 1'b1;
        return r;
    endfunction

    function automatic logic [8:0] model_outs(input int step, input logic [6:0] op, input logic [2:0] f3);
        logic [8:0] v = '0;
        bit csr_op = (op == 7'b1110011) && (f3 >= 3'd1) && (f3 <= 3'd3);
        case (step)
            M_RESET:  v[B_RST] = 1'b1;
            M_FETCH:  v[B_RD1] = 1'b1;
            M_LOADWB: begin v[B_RW] = 1'b1; v[B_PC] = 1'b1; end
            M_TRAP:   begin v[B_INT] = 1'b1; v[B_PC] = 1'b1; end
            default: begin
                v[B_PC]   = (op != 7'b0000011);
                v[B_RD2]  = (op == 7'b0000011);
                v[B_WE2]  = (op == 7'b0100011);
                v[B_RW]   = is_alu(op) || csr_op;
                v[B_CSR]  = csr_op;
                v[B_MRET] = (op == 7'b1110011) && (f3 == 3'd0);
            end
        endcase
        return v;
    endfunction

    function automatic logic [8:0] observed();
        return {bus.PCWrite, bus.regWrite, bus.memWE2, bus.memRDEN1, bus.memRDEN2,
                bus.reset, bus.csr_WE, bus.int_taken, bus.mret_exec};
    endfunction

    // One clock: drive inputs mid-cycle, compare, then advance the model across the edge.
    task automatic cycle(input string tag, input logic rst, input logic irq, input logic en,
                         input logic [6:0] op, input logic [2:0] f3);
        bit leave_ok;
        @(negedge CLK);
        RST         = rst;
        bus.intr    = irq;
        bus.mie     = en;
        bus.ir6_0   = op;
        bus.ir14_12 = f3;
        #1;
        check_eq(tag, observed(), model_outs(m_step, op, f3));
        if (rst) begin
            m_step    = M_RESET;
            m_pending = 1'b0;
        end else begin
            leave_ok = (m_step == M_LOADWB) || (m_step == M_EXEC && op != 7'b0000011);
            if (m_step == M_TRAP) m_pending = irq;
            else                  m_pending = m_pending | irq;
            if (leave_ok)
                m_step = ((m_pending | irq) & en) ? M_TRAP : M_FETCH;
            else if (m_step == M_EXEC)
                m_step = M_LOADWB;
            else if (m_step == M_FETCH)
                m_step = M_EXEC;
            else
                m_step = M_FETCH;
        end
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       rst_r, irq_r, en_r;
        n_checks    = 0;
        n_errors    = 0;
        RST         = 1'b1;
        bus.intr    = 1'b0;
        bus.mie     = 1'b0;
        bus.ir6_0   = 7'b0;
        bus.ir14_12 = 3'b0;
        @(posedge CLK);
        m_step    = M_RESET;
        m_pending = 1'b0;

        // Reset held, released, then first fetch
        cycle("rst_hold0",  1, 0, 1, 7'h00, 3'd0);
        cycle("rst_hold1",  1, 0, 1, 7'h00, 3'd0);
        cycle("rst_after",  0, 0, 1, 7'h00, 3'd0);
        // R-type
        cycle("rtype_fetch", 0, 0, 1, 7'b0110011, 3'd0);
        cycle("rtype_exec",  0, 0, 1, 7'b0110011, 3'd0);
        // Load through write-back
        cycle("load_fetch",  0, 0, 1, 7'b0000011, 3'd2);
        cycle("load_exec",   0, 0, 1, 7'b0000011, 3'd2);
        cycle("load_wb",     0, 0, 1, 7'b0000011, 3'd2);
        // Interrupt pulse in FETCH with mie=1
        cycle("irq_fetch",   0, 1, 1, 7'b0010011, 3'd0);
        cycle("irq_exec",    0, 0, 1, 7'b0010011, 3'd0);
        cycle("irq_intr",    0, 0, 1, 7'b0010011, 3'd0);
        cycle("irq_refetch", 0, 0, 1, 7'b0010011, 3'd0);
        cycle("irq_cleared", 0, 0, 1, 7'b0010011, 3'd0);
        // Pulse while masked for three instructions, then unmask
        cycle("mask_fetch",  0, 1, 0, 7'b0100011, 3'd0);
        cycle("mask_exec0",  0, 0, 0, 7'b0100011, 3'd0);
        for (int i = 0; i < 2; i++) begin
            cycle("mask_fetchn", 0, 0, 0, 7'b1100011, 3'd0);
            cycle("mask_execn",  0, 0, 0, 7'b1100011, 3'd0);
        end
        cycle("unmask_fetch", 0, 0, 1, 7'b0110111, 3'd0);
        cycle("unmask_exec",  0, 0, 1, 7'b0110111, 3'd0);
        cycle("unmask_intr",  0, 0, 1, 7'b0110111, 3'd0);
        // mret and CSR write
        cycle("mret_fetch",  0, 0, 1, 7'b1110011, 3'd0);
        cycle("mret_exec",   0, 0, 1, 7'b1110011, 3'd0);
        cycle("csr_fetch",   0, 0, 1, 7'b1110011, 3'd1);
        cycle("csr_exec",    0, 0, 1, 7'b1110011, 3'd1);
        cycle("sys_fetch",   0, 0, 1, 7'b1110011, 3'd5);
        cycle("sys_other",   0, 0, 1, 7'b1110011, 3'd5);
        // Interrupt pending across a load waits for write-back; then reset mid-load
        cycle("ldirq_fetch", 0, 1, 1, 7'b0000011, 3'd0);
        cycle("ldirq_exec",  0, 0, 1, 7'b0000011, 3'd0);
        cycle("ldirq_wb",    0, 0, 1, 7'b0000011, 3'd0);
        cycle("ldirq_intr",  0, 0, 1, 7'b0000011, 3'd0);
        cycle("ldrst_fetch", 0, 0, 1, 7'b0000011, 3'd0);
        cycle("ldrst_exec",  0, 0, 1, 7'b0000011, 3'd0);
        cycle("ldrst_wb",    1, 1, 1, 7'b0000011, 3'd0);
        cycle("ldrst_init",  0, 0, 1, 7'b0000011, 3'd0);
        cycle("ldrst_fetch2",0, 0, 1, 7'b1111111, 3'd0);
        cycle("nop_exec",    0, 0, 1, 7'b1111111, 3'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 60) == 0);
            irq_r = ($urandom_range(0, 5) == 0);
            en_r  = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 4) == 0) op = 7'($urandom);
            else                           op = all_ops[$urandom_range(0, 9)];
            f3 = 3'($urandom);
            cycle("rand", rst_r, irq_r, en_r, op, f3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
